// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared state encoding and defaults for the MEM-stage data memory
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  localparam int DMEM_LATENCY = 2;
  localparam int DMEM_ADDR_W  = 6;

  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word RAM, synchronous write, registered read
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Contents survive reset; reset only suppresses a write landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset && en && we) begin
      mem[addr] <= wdata;
    end
  end

  // A write on the same edge takes the port, so the read register keeps its value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (clr) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with stall and ack handshake
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  dmem_state_t state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        enter_done;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_mis;
  logic        unused_addr_hi;

  // With LATENCY=1 the access completes on the capture edge, so live inputs feed the array.
  always_comb begin
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    enter_done = 1'b0;
    if (state == IDLE) begin
      acc_we     = we;
      acc_addr   = addr;
      acc_wdata  = wdata;
      enter_done = req && (LATENCY == 1);
    end else if (state == WAIT) begin
      enter_done = (cnt <= 4'd1);
    end
  end

  assign acc_mis        = misaligned(acc_addr);
  assign busy           = ((state == IDLE) && req) || (state == WAIT);
  assign unused_addr_hi = ^acc_addr[31:ADDR_W+2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
    end else begin
      ack <= enter_done;
      err <= enter_done && acc_mis;
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= 4'(LATENCY - 1);
            state   <= (LATENCY == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (enter_done),
    .we    (acc_we && !acc_mis),
    .clr   (enter_done && acc_mis),
    .addr  (acc_addr[ADDR_W+1:2]),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        busy  [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        err   [2];

  int errors = 0;
  int checks = 0;
  int lat_of [2] = '{2, 1};
  logic [31:0] mref [2][64];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  dmem_responder #(.ADDR_W(6), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .ack(ack[0]), .rdata(rdata[0]), .err(err[0])
  );

  dmem_responder #(.ADDR_W(6), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .ack(ack[1]), .rdata(rdata[1]), .err(err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access with req held until ack; checked against the reference memory.
  task automatic run_op(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
    int   lat;
    int   bcnt;
    logic bsy_ack;
    bit   mis;
    int   idx;
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    lat = 0; bcnt = 0; rd = '0; e = 1'b0; bsy_ack = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack[i]) begin
        lat = c; rd = rdata[i]; e = err[i]; bsy_ack = busy[i];
        break;
      end
      if (busy[i]) bcnt++;
    end
    @(posedge clk); #1;
    req[i] = 1'b0;
    mis = (a[1:0] != 2'b00);
    idx = int'(a[7:2]);
    chk($sformatf("latency[%0d]", i), 32'(lat), 32'(lat_of[i] + 1));
    chk($sformatf("busy_cycles[%0d]", i), 32'(bcnt), 32'(lat_of[i]));
    chk($sformatf("busy_at_ack[%0d]", i), 32'(bsy_ack), 32'd0);
    chk($sformatf("err[%0d] a=%h", i, a), 32'(e), 32'(mis));
    if (!w) chk($sformatf("rdata[%0d] a=%h", i, a), rd, mis ? 32'h0 : mref[i][idx]);
    else if (!mis) mref[i][idx] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [9];
    logic [31:0] rd;
    logic        e;
    logic [31:0] prior;
    logic [31:0] a;
    int          nacks;
    int          op;
    logic        got;
    int          ack_cyc [$];
    logic [31:0] rds [$];

    // Reset held across two edges with a pending request
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    req[0] = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_busy[%0d]", i), 32'(busy[i]), 32'd0);
      chk($sformatf("reset_ack[%0d]", i), 32'(ack[i]), 32'd0);
      chk($sformatf("reset_err[%0d]", i), 32'(err[i]), 32'd0);
      chk($sformatf("reset_rdata[%0d]", i), rdata[i], 32'd0);
    end

    // Give every word a known value so loads are never undefined
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 64; w++)
        run_op(i, 1'b1, 32'(w * 4), 32'h5A000000 ^ (32'(w) * 32'h01010101) ^ 32'(i), rd, e);

    tbl[0] = '{1'b1, 32'h00000010, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 32'h00000010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2] = '{1'b1, 32'h00000012, 32'h12345678, 1'b0, 32'h0,        1'b1};
    tbl[3] = '{1'b0, 32'h00000010, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[4] = '{1'b1, 32'h00000100, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
    tbl[5] = '{1'b0, 32'h00000000, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    tbl[6] = '{1'b0, 32'h00000013, 32'h0,        1'b1, 32'h0,        1'b1};
    tbl[7] = '{1'b0, 32'hFFFFFF10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
    tbl[8] = '{1'b0, 32'h00000100, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0};
    for (int k = 0; k < 9; k++) begin
      run_op(0, tbl[k].w, tbl[k].a, tbl[k].d, rd, e);
      chk($sformatf("tbl_err[%0d]", k), 32'(e), 32'(tbl[k].exp_err));
      if (tbl[k].chk_rd) chk($sformatf("tbl_rdata[%0d]", k), rd, tbl[k].exp_rd);
    end

    // Reset during WAIT drops the access and its store
    prior = mref[0][8];
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h11111111;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; req[0] = 1'b0;
    nacks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack[0]) nacks++;
    end
    chk("abort_no_ack", 32'(nacks), 32'd0);
    run_op(0, 1'b0, 32'h20, 32'h0, rd, e);
    chk("abort_prior_kept", rd, prior);

    // LATENCY=1 back-to-back load, store, load with req never dropped
    prior = mref[1][17];
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h44; wdata[1] = 32'h0;
    op = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      got = ack[1];
      if (got) begin
        ack_cyc.push_back(c);
        rds.push_back(rdata[1]);
      end
      @(posedge clk); #1;
      if (got) begin
        op++;
        if (op == 1) begin
          we[1] = 1'b1; wdata[1] = 32'h0BADF00D;
        end else if (op == 2) begin
          we[1] = 1'b0;
        end else begin
          req[1] = 1'b0;
        end
      end
    end
    req[1] = 1'b0;
    chk("b2b_ack_count", 32'(ack_cyc.size()), 32'd3);
    for (int k = 0; k < ack_cyc.size() && k < 3; k++)
      chk($sformatf("b2b_ack_cycle[%0d]", k), 32'(ack_cyc[k]), 32'(2 * k + 2));
    if (rds.size() >= 3) begin
      chk("b2b_first_load", rds[0], prior);
      chk("b2b_second_load", rds[2], 32'h0BADF00D);
    end
    mref[1][17] = 32'h0BADF00D;

    // Randomized traffic on both latencies
    for (int k = 0; k < 80; k++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op(k % 2, 1'($urandom_range(0, 1)), a, $urandom, rd, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
